// File: rtl/mod_busarb_pkg.sv
// plp_bus_pkg: shared definitions for the PLP memory-mapped data bus.
//   DRW_*      : bus operation codes carried on the 2-bit drw lines.
//   state_t    : arbiter FSM encoding (IDLE -> ISSUE -> RESP -> IDLE).
//   DEF_AW/DW  : default address and data widths.
package plp_bus_pkg;

    localparam logic [1:0] DRW_NONE  = 2'b00;
    localparam logic [1:0] DRW_WRITE = 2'b01;
    localparam logic [1:0] DRW_READ  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Only plain reads return slave data; writes and malformed ops return 0.
    function automatic logic is_read(input logic [1:0] drw);
        return drw == DRW_READ;
    endfunction

endpackage

// File: rtl/mod_busarb_rrpick.sv
// mod_rrpick: combinational 2-way round-robin winner select.
//   i_req[1:0] : request vector (bit n = master n)
//   i_rr_ptr   : master favoured when both request
//   o_any      : at least one request present
//   o_winner   : selected master index (meaningful only when o_any=1)
module mod_rrpick (
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic       o_any,
    output logic       o_winner
);

    assign o_any    = |i_req;
    // Contention resolves to the pointer; otherwise the lone requester wins.
    assign o_winner = (&i_req) ? i_rr_ptr : i_req[1];

endmodule

// File: rtl/mod_busarb.sv
// mod_busarb: two-master / one-slave round-robin arbiter for the PLP data bus.
//   clk, rst           : clock, synchronous active-high reset
//   m0_* / m1_*        : master request ports (req, addr, drw, din in; ack, dout out)
//   s_de/daddr/drw/din : slave access outputs; s_dout is the slave read data
//   busy               : transaction in ISSUE or RESP
//   owner              : master granted for the current transaction
//   dbg_state          : current FSM state
// Handshake: a master raises req with addr/drw/din and holds it until its ack.
// The request is latched in IDLE; ack is a single-cycle pulse, and dout is
// valid in that cycle and held until the same master's next ack.
module mod_busarb
    import plp_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [1:0]    m0_drw,
    input  logic [DW-1:0] m0_din,
    output logic          m0_ack,
    output logic [DW-1:0] m0_dout,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [1:0]    m1_drw,
    input  logic [DW-1:0] m1_din,
    output logic          m1_ack,
    output logic [DW-1:0] m1_dout,
    output logic          s_de,
    output logic [AW-1:0] s_daddr,
    output logic [1:0]    s_drw,
    output logic [DW-1:0] s_din,
    input  logic [DW-1:0] s_dout,
    output logic          busy,
    output logic          owner,
    output state_t        dbg_state
);

    state_t        r_state;
    logic          r_rr_ptr;
    logic [3:0]    r_cnt;
    logic [1:0]    r_drw;      // latched op; s_drw is zeroed outside ISSUE
    logic          r_owner;
    logic          r_busy;
    logic          r_s_de;
    logic [AW-1:0] r_s_daddr;
    logic [1:0]    r_s_drw;
    logic [DW-1:0] r_s_din;
    logic [1:0]    r_ack;
    logic [DW-1:0] r_dout0;
    logic [DW-1:0] r_dout1;

    logic          w_any;
    logic          w_winner;
    logic [DW-1:0] w_rdata;

    mod_rrpick u_rrpick (
        .i_req    ({m1_req, m0_req}),
        .i_rr_ptr (r_rr_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    assign w_rdata = is_read(r_drw) ? s_dout : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= 1'b0;
            r_cnt     <= '0;
            r_drw     <= DRW_NONE;
            r_owner   <= 1'b0;
            r_busy    <= 1'b0;
            r_s_de    <= 1'b0;
            r_s_daddr <= '0;
            r_s_drw   <= DRW_NONE;
            r_s_din   <= '0;
            r_ack     <= 2'b00;
            r_dout0   <= '0;
            r_dout1   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        // The slave address/data registers double as the
                        // request latch, so later master changes are ignored.
                        r_owner   <= w_winner;
                        r_drw     <= w_winner ? m1_drw : m0_drw;
                        r_s_daddr <= w_winner ? m1_addr : m0_addr;
                        r_s_din   <= w_winner ? m1_din : m0_din;
                        r_s_drw   <= w_winner ? m1_drw : m0_drw;
                        r_s_de    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= 4'(WAIT_CYCLES);
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == 4'd0) begin
                        // Read data is captured on the last access cycle and
                        // lands directly in the owner's dout register, which
                        // becomes visible together with the ack in RESP.
                        if (r_owner) r_dout1 <= w_rdata;
                        else         r_dout0 <= w_rdata;
                        r_ack[r_owner] <= 1'b1;
                        r_s_de         <= 1'b0;
                        r_s_drw        <= DRW_NONE;
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_ack    <= 2'b00;
                    r_rr_ptr <= ~r_owner;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ack    = r_ack[0];
    assign m1_ack    = r_ack[1];
    assign m0_dout   = r_dout0;
    assign m1_dout   = r_dout1;
    assign s_de      = r_s_de;
    assign s_daddr   = r_s_daddr;
    assign s_drw     = r_s_drw;
    assign s_din     = r_s_din;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_busarb.sv
module tb_mod_busarb;
  import plp_bus_pkg::*;

  localparam int W  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          req;
  logic [1:0][AW-1:0]  maddr;
  logic [1:0][1:0]     mdrw;
  logic [1:0][DW-1:0]  mdin;
  logic [1:0]          ack;
  logic [1:0][DW-1:0]  dout;
  logic                s_de;
  logic [AW-1:0]       s_daddr;
  logic [1:0]          s_drw;
  logic [DW-1:0]       s_din;
  logic [DW-1:0]       s_dout;
  logic                busy;
  logic                owner;
  state_t              dbg_state;

  // Board-id style slave: fixed words at 0 and 4, address-derived elsewhere.
  function automatic logic [31:0] slave_f(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0303;
      32'd4:   return 32'h017d_7840;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction
  assign s_dout = slave_f(s_daddr);

  mod_busarb #(.WAIT_CYCLES(W), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_addr(maddr[0]), .m0_drw(mdrw[0]), .m0_din(mdin[0]),
    .m0_ack(ack[0]), .m0_dout(dout[0]),
    .m1_req(req[1]), .m1_addr(maddr[1]), .m1_drw(mdrw[1]), .m1_din(mdin[1]),
    .m1_ack(ack[1]), .m1_dout(dout[1]),
    .s_de(s_de), .s_daddr(s_daddr), .s_drw(s_drw), .s_din(s_din), .s_dout(s_dout),
    .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: a transaction granted at edge g drives the slave
  // for edges g..g+W, acks at edge g+W+1, and the arbiter samples again at g+W+3.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout[2];
  int            n = 0;
  int            g = 0;
  int            free_at = 0;
  bit            active = 0;
  bit            rr = 0;
  bit            m_own = 0;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_drw;
  logic [DW-1:0] m_din;
  bit            auto_drop = 1;

  task automatic model_edge();
    n++;
    if (rst) begin
      active = 0; free_at = n + 1; rr = 0;
      exp_dout[0] = '0; exp_dout[1] = '0;
      exp_q.delete();
      return;
    end
    if (active && n == g + W + 1) begin
      exp_dout[m_own] = exp_q.pop_front();
      rr = !m_own;
    end else if (active && n > g + W + 1) begin
      active = 0;
    end
    if (!active && n >= free_at && req != 2'b00) begin
      if (req == 2'b11) m_own = rr;
      else              m_own = req[1];
      m_addr = maddr[m_own];
      m_drw  = mdrw[m_own];
      m_din  = mdin[m_own];
      exp_q.push_back((m_drw == DRW_READ) ? slave_f(m_addr) : '0);
      g = n; free_at = n + W + 3; active = 1;
    end
  endtask

  task automatic check_cycle();
    bit de_e, busy_e;
    bit [1:0] ack_e;
    logic [1:0] st_e;
    busy_e = active && (n <= g + W + 1);
    de_e   = active && (n <= g + W);
    ack_e  = 2'b00;
    if (active && n == g + W + 1) ack_e[m_own] = 1'b1;
    st_e = de_e ? ST_ISSUE : (busy_e ? ST_RESP : ST_IDLE);
    chk("s_de", 32'(s_de), 32'(de_e));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("ack0", 32'(ack[0]), 32'(ack_e[0]));
    chk("ack1", 32'(ack[1]), 32'(ack_e[1]));
    chk("dout0", dout[0], exp_dout[0]);
    chk("dout1", dout[1], exp_dout[1]);
    chk("s_drw", 32'(s_drw), de_e ? 32'(m_drw) : 32'(DRW_NONE));
    chk("state", 32'(dbg_state), 32'(st_e));
    if (de_e) begin
      chk("s_daddr", s_daddr, m_addr);
      chk("s_din", s_din, m_din);
    end
    if (busy_e) chk("owner", 32'(owner), 32'(m_own));
    if (auto_drop && ack_e != 2'b00) req[m_own] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic [AW-1:0] a, input logic [1:0] d, input logic [DW-1:0] wd);
    maddr[m] = a; mdrw[m] = d; mdin[m] = wd; req[m] = 1'b1;
  endtask

  task automatic wait_any_ack(input int bound, output int who, output int at);
    who = -1; at = n;
    for (int i = 0; i < bound; i++) begin
      step();
      if (ack != 2'b00) begin
        who = ack[1] ? 1 : 0;
        at  = n;
        break;
      end
    end
    chk("ack_seen", 32'(who >= 0), 32'd1);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd4;
      2:       return 32'd8;
      default: return 32'($urandom_range(0, 1023)) << 2;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int who, at, t0, prev, de_cnt;
    req = '0; maddr = '0; mdrw = '0; mdin = '0;
    exp_dout[0] = '0; exp_dout[1] = '0;

    @(negedge clk);
    step(); step(); step();
    chk("rst_daddr", s_daddr, 32'd0);
    chk("rst_din", s_din, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    step();

    // Lone read from master 0.
    drive(0, 32'd0, DRW_READ, 32'd0);
    t0 = n + 1;
    step();
    chk("lone_de", 32'(s_de), 32'd1);
    wait_any_ack(12, who, at);
    chk("lone_who", 32'(who), 32'd0);
    chk("lone_lat", 32'(at - t0), 32'(W + 1));
    chk("lone_dout", dout[0], 32'h0000_0303);
    step();

    // Both masters reading continuously from a fresh reset: strict alternation.
    rst = 1'b1; step(); rst = 1'b0;
    auto_drop = 0;
    drive(0, 32'd0, DRW_READ, 32'd0);
    drive(1, 32'd4, DRW_READ, 32'd0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(12, who, at);
      chk("alt_owner", 32'(who), 32'(k % 2));
      if (who == 0) chk("alt_dout0", dout[0], 32'h0000_0303);
      else if (who == 1) chk("alt_dout1", dout[1], 32'h017d_7840);
      if (k > 0) chk("alt_spacing", 32'(at - prev), 32'(W + 3));
      prev = at;
    end
    req = 2'b00;
    auto_drop = 1;
    step(); step();

    // Write from master 1 through the wait states.
    drive(1, 32'd8, DRW_WRITE, 32'hDEAD_BEEF);
    t0 = n + 1;
    step();
    de_cnt = 0;
    for (int i = 0; i < 12 && s_de; i++) begin
      de_cnt++;
      chk("wr_addr", s_daddr, 32'd8);
      chk("wr_din", s_din, 32'hDEAD_BEEF);
      chk("wr_drw", 32'(s_drw), 32'(DRW_WRITE));
      step();
    end
    chk("wr_de_len", 32'(de_cnt), 32'(W + 1));
    chk("wr_ack", 32'(ack[1]), 32'd1);
    chk("wr_lat", 32'(n - t0), 32'(W + 1));
    chk("wr_dout", dout[1], 32'd0);
    step();

    // Address changed after the latch is ignored.
    drive(0, 32'd4, DRW_READ, 32'd0);
    step();
    maddr[0] = 32'd0;
    step();
    chk("hold_addr", s_daddr, 32'd4);
    wait_any_ack(12, who, at);
    chk("hold_who", 32'(who), 32'd0);
    chk("hold_dout", dout[0], 32'h017d_7840);
    step();

    // Reset in the second ISSUE cycle abandons the access.
    drive(0, 32'd0, DRW_READ, 32'd0);
    drive(1, 32'd4, DRW_READ, 32'd0);
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_mid_de", 32'(s_de), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_first_owner", 32'(owner), 32'd0);
    chk("rst_first_busy", 32'(busy), 32'd1);
    wait_any_ack(12, who, at);
    chk("rst_ack_a", 32'(who), 32'd0);
    wait_any_ack(12, who, at);
    chk("rst_ack_b", 32'(who), 32'd1);
    step();

    // Malformed op: issued as-is, acked with zero data, pointer still rotates.
    drive(0, 32'd4, 2'b11, 32'h1234_5678);
    step();
    chk("inv_drw", 32'(s_drw), 32'h3);
    wait_any_ack(12, who, at);
    chk("inv_who", 32'(who), 32'd0);
    chk("inv_dout", dout[0], 32'd0);
    drive(0, 32'd0, DRW_READ, 32'd0);
    drive(1, 32'd4, DRW_READ, 32'd0);
    step(); step();
    chk("inv_next_owner", 32'(owner), 32'd1);
    wait_any_ack(12, who, at);
    wait_any_ack(12, who, at);
    step();

    // Random traffic: withdrawals, late address/data changes, all op codes.
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if (!(active && m_own == m) && $urandom_range(0, 2) == 0)
            drive(m, pick_addr(), 2'($urandom_range(0, 3)), $urandom);
        end else begin
          case ($urandom_range(0, 15))
            0:          req[m] = 1'b0;
            1, 2, 3, 4: begin maddr[m] = pick_addr(); mdin[m] = $urandom; end
            default:    ;
          endcase
        end
      end
      step();
    end
    req = 2'b00;
    for (int c = 0; c < 3 * (W + 3); c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
